player_health: RTL and testbench

PLAYER_HEALTH -- requirements
Module: player_health

---
 rtl/game_pkg.sv | 34 +++
 rtl/frame_timer.sv | 40 ++++
 rtl/player_health.sv | 177 +++++++++++++++++
 tb/tb_player_health.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions.
//   - Game-state encodings driven by the top-level game controller.
//   - Health and frame-timer widths.
//   - Player-health FSM state type.
//   - sat_add: saturating add computed one bit wider so it never wraps.
package game_pkg;

  localparam logic [7:0] ST_MENU = 8'd0;
  localparam logic [7:0] ST_PLAY = 8'd1;
  localparam logic [7:0] ST_OVER = 8'd2;

  localparam int HEALTH_W = 10;
  localparam int TIMER_W  = 16;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'd0,
    FSM_ALIVE  = 2'd1,
    FSM_INVULN = 2'd2,
    FSM_DEAD   = 2'd3
  } fsm_t;

  // Computes a + b and clamps the result to lim.
  function automatic logic [HEALTH_W-1:0] sat_add(
    input logic [HEALTH_W-1:0] a,
    input logic [HEALTH_W-1:0] b,
    input logic [HEALTH_W-1:0] lim
  );
    logic [HEALTH_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, lim}) return lim;
    else return s[HEALTH_W-1:0];
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter advanced by frame ticks.
// Ports:
//   Clk, Reset  : clock, synchronous active-high reset (count -> 0)
//   i_clear     : force count to 0
//   i_load      : load i_load_val (lower priority than i_clear)
//   i_load_val  : value to load
//   i_tick      : decrement by one; holds at 0
//   o_count     : current count
//   o_done      : count is 0
module frame_timer
  import game_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic [W-1:0] o_count,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (Reset || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/player_health.sv
// Player health tracker: damage with invulnerability window, pickups,
// fall-out death and periodic regeneration while idle.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   frame_tick          : one-Clk pulse per video frame
//   state               : game state (1 = play, anything else resets to IDLE)
//   damage_req/amt      : damage request pulse and magnitude
//   heal_req/amt        : heal request pulse and magnitude
//   fall_out            : level, player has fallen off the screen
//   health              : registered current health
//   invuln              : high exactly while in INVULN
//   dead                : one-Clk pulse on entering DEAD
//   o_fsm_state         : current FSM state, for observation
// Handshake: all inputs are sampled on the rising edge of Clk; every
// response appears on the registered outputs exactly one Clk later. There is
// no backpressure.
module player_health
  import game_pkg::*;
#(
  parameter int MAX_HEALTH    = 100,
  parameter int INVULN_FRAMES = 60,
  parameter int REGEN_PERIOD  = 120,
  parameter int REGEN_AMT     = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_tick,
  input  logic [7:0]          state,
  input  logic                damage_req,
  input  logic [HEALTH_W-1:0] damage_amt,
  input  logic                heal_req,
  input  logic [HEALTH_W-1:0] heal_amt,
  input  logic                fall_out,
  output logic [HEALTH_W-1:0] health,
  output logic                invuln,
  output logic                dead,
  output fsm_t                o_fsm_state
);

  localparam logic [HEALTH_W-1:0] MAX_H   = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] REGEN_A = HEALTH_W'(REGEN_AMT);

  fsm_t                r_fsm;
  logic [HEALTH_W-1:0] r_health;
  logic                r_invuln;
  logic                r_dead;

  fsm_t                w_fsm_nxt;
  logic [HEALTH_W-1:0] w_health_nxt;
  logic [HEALTH_W-1:0] w_heal_sum;
  logic [HEALTH_W-1:0] w_dmg_res;
  logic                w_regen_run;
  logic                w_regen_fire;

  logic                w_inv_clear, w_inv_load, w_inv_tick, w_inv_done;
  logic [TIMER_W-1:0]  w_inv_count;
  logic                w_rg_clear, w_rg_load, w_rg_tick, w_rg_done;
  logic [TIMER_W-1:0]  w_rg_count;

  frame_timer #(.W(TIMER_W)) u_inv_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_clear    (w_inv_clear),
    .i_load     (w_inv_load),
    .i_load_val (TIMER_W'(INVULN_FRAMES)),
    .i_tick     (w_inv_tick),
    .o_count    (w_inv_count),
    .o_done     (w_inv_done)
  );

  // Regen timer holds frames remaining until the next step; 0 means
  // "freshly cleared", so the first counted tick loads PERIOD-1.
  frame_timer #(.W(TIMER_W)) u_regen_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_clear    (w_rg_clear),
    .i_load     (w_rg_load),
    .i_load_val (TIMER_W'(REGEN_PERIOD - 1)),
    .i_tick     (w_rg_tick),
    .o_count    (w_rg_count),
    .o_done     (w_rg_done)
  );

  assign w_heal_sum  = heal_req ? sat_add(r_health, heal_amt, MAX_H) : r_health;
  assign w_dmg_res   = (damage_amt >= r_health) ? '0 : (r_health - damage_amt);
  assign w_regen_run = (r_fsm == FSM_ALIVE) && frame_tick && (r_health != MAX_H);
  assign w_regen_fire = w_regen_run &&
                        ((w_rg_count == TIMER_W'(1)) || (w_rg_done && (REGEN_PERIOD == 1)));

  always_comb begin
    w_fsm_nxt    = r_fsm;
    w_health_nxt = r_health;
    w_inv_clear  = 1'b0;
    w_inv_load   = 1'b0;
    w_inv_tick   = 1'b0;
    w_rg_clear   = 1'b0;
    w_rg_load    = 1'b0;
    w_rg_tick    = 1'b0;

    if (state != ST_PLAY) begin
      w_fsm_nxt    = FSM_IDLE;
      w_health_nxt = MAX_H;
      w_inv_clear  = 1'b1;
      w_rg_clear   = 1'b1;
    end else begin
      case (r_fsm)
        FSM_IDLE: begin
          w_fsm_nxt    = FSM_ALIVE;
          w_health_nxt = MAX_H;
          w_inv_clear  = 1'b1;
          w_rg_clear   = 1'b1;
        end
        FSM_ALIVE: begin
          if (fall_out) begin
            w_health_nxt = '0;
            w_fsm_nxt    = FSM_DEAD;
          end else if (damage_req) begin
            // Accepted damage discards any simultaneous heal.
            w_health_nxt = w_dmg_res;
            w_rg_clear   = 1'b1;
            if (w_dmg_res == '0) begin
              w_fsm_nxt = FSM_DEAD;
            end else begin
              w_fsm_nxt  = FSM_INVULN;
              w_inv_load = 1'b1;
            end
          end else begin
            w_health_nxt = w_heal_sum;
            if (w_regen_fire) begin
              w_health_nxt = sat_add(w_heal_sum, REGEN_A, MAX_H);
              w_rg_clear   = 1'b1;
            end else if (w_regen_run) begin
              if (w_rg_done) w_rg_load = 1'b1;
              else           w_rg_tick = 1'b1;
            end
          end
        end
        FSM_INVULN: begin
          if (fall_out) begin
            w_health_nxt = '0;
            w_fsm_nxt    = FSM_DEAD;
          end else begin
            w_health_nxt = w_heal_sum;
            w_inv_tick   = frame_tick;
            // Leave on the same edge the timer reaches zero.
            if (w_inv_done || (frame_tick && (w_inv_count == TIMER_W'(1)))) begin
              w_fsm_nxt = FSM_ALIVE;
            end
          end
        end
        default: begin
          w_health_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fsm    <= FSM_IDLE;
      r_health <= MAX_H;
      r_invuln <= 1'b0;
      r_dead   <= 1'b0;
    end else begin
      r_fsm    <= w_fsm_nxt;
      r_health <= w_health_nxt;
      r_invuln <= (w_fsm_nxt == FSM_INVULN);
      r_dead   <= (w_fsm_nxt == FSM_DEAD) && (r_fsm != FSM_DEAD);
    end
  end

  assign health      = r_health;
  assign invuln      = r_invuln;
  assign dead        = r_dead;
  assign o_fsm_state = r_fsm;

endmodule

// File: tb/tb_player_health.sv
module tb_player_health;
  import game_pkg::*;

  localparam int MAXH    = 100;
  localparam int INV     = 60;
  localparam int REGEN_P = 120;
  localparam int REGEN_A = 1;
  localparam int EW      = 14;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick, damage_req, heal_req, fall_out;
  logic [7:0] state;
  logic [9:0] damage_amt, heal_amt;
  logic [9:0] health;
  logic       invuln, dead;
  fsm_t       o_fsm_state;

  always #5 Clk = ~Clk;

  player_health #(
    .MAX_HEALTH(MAXH), .INVULN_FRAMES(INV), .REGEN_PERIOD(REGEN_P), .REGEN_AMT(REGEN_A)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .state(state),
    .damage_req(damage_req), .damage_amt(damage_amt),
    .heal_req(heal_req), .heal_amt(heal_amt), .fall_out(fall_out),
    .health(health), .invuln(invuln), .dead(dead), .o_fsm_state(o_fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp, mon_got;
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 alive, 2 invulnerable, 3 dead.
  // m_inv counts frames left in the window, m_regen counts frames elapsed.
  int m_mode = 0, m_health = MAXH, m_inv = 0, m_regen = 0;
  bit m_dead = 0;

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    int old_mode, old_h;
    old_mode = m_mode;
    old_h    = m_health;
    if (Reset || state != 8'd1) begin
      m_mode = 0; m_health = MAXH; m_inv = 0; m_regen = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_health = MAXH; m_inv = 0; m_regen = 0; end
        1: begin
          if (fall_out) begin
            m_health = 0; m_mode = 3;
          end else if (damage_req) begin
            m_health = (int'(damage_amt) >= old_h) ? 0 : old_h - int'(damage_amt);
            m_regen  = 0;
            if (m_health == 0) m_mode = 3;
            else begin m_mode = 2; m_inv = INV; end
          end else begin
            if (heal_req) m_health = min_i(old_h + int'(heal_amt), MAXH);
            if (frame_tick && old_h != MAXH) begin
              m_regen++;
              if (m_regen == REGEN_P) begin
                m_health = min_i(m_health + REGEN_A, MAXH);
                m_regen  = 0;
              end
            end
          end
        end
        2: begin
          if (fall_out) begin
            m_health = 0; m_mode = 3;
          end else begin
            if (heal_req) m_health = min_i(old_h + int'(heal_amt), MAXH);
            if (frame_tick) begin
              m_inv--;
              if (m_inv <= 0) begin m_inv = 0; m_mode = 1; end
            end
          end
        end
        default: ;
      endcase
    end
    m_dead = (m_mode == 3) && (old_mode != 3);
  endtask

  function automatic logic [EW-1:0] model_vec();
    fsm_t f;
    case (m_mode)
      0:       f = FSM_IDLE;
      1:       f = FSM_ALIVE;
      2:       f = FSM_INVULN;
      default: f = FSM_DEAD;
    endcase
    return {f, 10'(m_health), (m_mode == 2), m_dead};
  endfunction

  // Monitor: every Clk the DUT presents a new output word.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {o_fsm_state, health, invuln, dead};
      n_checks++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL cycle_out t=%0t fsm/health/invuln/dead got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                 $time, mon_got[13:12], mon_got[11:2], mon_got[1], mon_got[0],
                 mon_exp[13:12], mon_exp[11:2], mon_exp[1], mon_exp[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are set at a falling edge; one call covers one Clk.
  task automatic step();
    model_step();
    exp_q.push_back(model_vec());
    @(negedge Clk);
    frame_tick = 1'b0;
    damage_req = 1'b0;
    heal_req   = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      step();
    end
  endtask

  task automatic hit(input int amt);
    damage_req = 1'b1; damage_amt = 10'(amt); step();
  endtask

  task automatic heal(input int amt);
    heal_req = 1'b1; heal_amt = 10'(amt); step();
  endtask

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; state = 8'd0; frame_tick = 1'b0; damage_req = 1'b0; heal_req = 1'b0;
    fall_out = 1'b0; damage_amt = '0; heal_amt = '0;
    @(negedge Clk);
    step(); step();
    Reset = 1'b0;
    chk("reset_health", int'(health), 100);
    chk("reset_invuln", int'(invuln), 0);
    chk("reset_dead", int'(dead), 0);
    chk("reset_fsm", int'(o_fsm_state), int'(FSM_IDLE));

    state = 8'd1; step();
    chk("play_fsm", int'(o_fsm_state), int'(FSM_ALIVE));
    chk("play_health", int'(health), 100);

    hit(30);
    chk("hit30_health", int'(health), 70);
    chk("hit30_invuln", int'(invuln), 1);
    hit(50);
    chk("invuln_ignore", int'(health), 70);
    frames(59);
    chk("invuln_59", int'(invuln), 1);
    frames(1);
    chk("invuln_60", int'(invuln), 0);
    hit(50);
    chk("hit50_health", int'(health), 20);

    heal(75);
    heal(20);
    chk("heal_sat", int'(health), 100);
    frames(60);
    hit(90);
    chk("hit90", int'(health), 10);
    frames(60);
    damage_req = 1'b1; damage_amt = 10'd40; heal_req = 1'b1; heal_amt = 10'd40; step();
    chk("dmg_heal_health", int'(health), 0);
    chk("dmg_heal_dead", int'(dead), 1);
    step();
    chk("dead_pulse_end", int'(dead), 0);
    chk("dead_fsm", int'(o_fsm_state), int'(FSM_DEAD));

    state = 8'd2; step();
    state = 8'd1; step();
    chk("revive_health", int'(health), 100);
    chk("revive_fsm", int'(o_fsm_state), int'(FSM_ALIVE));

    hit(30);
    chk("hit30b_invuln", int'(invuln), 1);
    fall_out = 1'b1; step(); fall_out = 1'b0;
    chk("fall_health", int'(health), 0);
    chk("fall_dead", int'(dead), 1);
    damage_req = 1'b1; damage_amt = 10'd5; heal_req = 1'b1; heal_amt = 10'd50; step();
    chk("dead_hold", int'(health), 0);

    state = 8'd0; step();
    state = 8'd1; step();
    hit(50);
    frames(60);
    frames(240);
    chk("regen_240", int'(health), 52);
    frames(119);
    hit(2);
    frames(60);
    frames(119);
    chk("regen_delay", int'(health), 50);
    frames(1);
    chk("regen_after", int'(health), 51);

    hit(10);
    chk("pre_reset_invuln", int'(invuln), 1);
    Reset = 1'b1; damage_req = 1'b1; damage_amt = 10'd5; step();
    Reset = 1'b0;
    chk("reset_mid_invuln", int'(invuln), 0);
    chk("reset_mid_health", int'(health), 100);
    step();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      Reset      = ($urandom_range(0, 499) == 0);
      state      = ($urandom_range(0, 299) == 0) ? 8'($urandom_range(0, 3)) : 8'd1;
      frame_tick = ($urandom_range(0, 2) == 0);
      damage_req = ($urandom_range(0, 24) == 0);
      damage_amt = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 60));
      heal_req   = ($urandom_range(0, 14) == 0);
      heal_amt   = ($urandom_range(0, 4) == 0) ? 10'($urandom) : 10'($urandom_range(0, 30));
      fall_out   = ($urandom_range(0, 399) == 0);
      step();
    end
    Reset = 1'b0; fall_out = 1'b0; state = 8'd0;
    step();

    repeat (3) @(negedge Clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
